trap_filter_cfg: RTL and testbench
==================================

Name: trap_filter_cfg

Overview:
Parametrised trapezoidal shaping filter for one ADC channel, the next generation of the fixed-coefficient shaper.
- Computes d = x[n]-x[n-k]-x[n-l]+x[n-k-l]; p += d; r = p + m*d; s += r.
- k, l, m and the output shift are loaded at run time through a config handshake.
- Adds a valid-qualified sample stream, a flush/warm-up sequencer, and a saturating scaled output.
- Sits between the ADC capture stage and the pulse-height / trigger logic.

Parameters:
ADC_W, 14, ADC sample width (unsigned input)
ACC_W, 32, width of the p and s accumulators (two's complement)
M_W, 16, width of unsigned m coefficient
OUT_W, 16, signed output width
MAX_DEPTH, 64, delay-line depth; k+l must not exceed it
K_DEF, 4, reset value of k
L_DEF, 8, reset value of l
M_DEF, 0, reset value of m
SHIFT_DEF, 4, reset value of output right-shift

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
in_valid  in  1  in_data valid this cycle
in_data  in  ADC_W  unsigned ADC sample
cfg_load  in  1  one-cycle request to load cfg_*
cfg_k  in  $clog2(MAX_DEPTH)+1  new k
cfg_l  in  $clog2(MAX_DEPTH)+1  new l
cfg_m  in  M_W  new m
cfg_shift  in  5  new arithmetic right-shift of s
cfg_busy  out  1  high while flushing
cfg_err  out  1  one-cycle pulse: rejected config
out_valid  out  1  out_data valid
out_data  out  OUT_W  signed, saturated (s >>> shift)
out_sat  out  1  saturation occurred on this output (qualified by out_valid)

Behaviour:
- Reset (async, active-high):
  - Parameters go to *_DEF values; pointers, accumulators and the pipeline clear.
  - out_valid, out_data, out_sat and cfg_err go to 0.
  - FSM enters FLUSH with cfg_busy=1.
- FSM states FLUSH, WARM, RUN:
  - FLUSH:
    - Writes 0 to one delay-line entry per cycle, MAX_DEPTH cycles total, addresses 0..MAX_DEPTH-1.
    - Clears p and s. in_valid samples are dropped; cfg_busy=1.
    - Then WARM; write pointer is 0.
  - WARM:
    - Samples accepted and processed normally, but out_valid is suppressed.
    - After k+l accepted samples, go to RUN.
  - RUN: every accepted sample yields out_valid.
- Config handshake:
  - cfg_load is honoured in WARM or RUN; it is ignored in FLUSH.
  - Valid config: 1 <= k <= l and k+l <= MAX_DEPTH. It is latched and the FSM goes to FLUSH next cycle.
  - Invalid config: parameters unchanged, cfg_err=1 for one cycle, state unchanged.
  - cfg_load together with in_valid: the sample is processed with the old config, then the flush starts.
- Delay line:
  - Circular buffer of MAX_DEPTH entries; write pointer increments and wraps on each accepted sample.
  - Taps are read at (wp-k), (wp-l), (wp-k-l) mod MAX_DEPTH, using pre-write contents. Current sample = x[n].
  - May be inferred as registers or RAM.
- Pipeline, fixed latency 2:
  - Sample accepted at edge N.
  - Edge N+1: d registered, as a signed ADC_W+2 value.
  - Edge N+2: p, s and out_data/out_valid/out_sat registered.
  - in_valid may be high every cycle; gaps simply produce gaps in the output.
- Arithmetic:
  - m*d is signed, M_W+ADC_W+3 bits, sign-extended to ACC_W.
  - p and s wrap modulo 2^ACC_W. This is intentional: exact cancellation returns them to 0.
- Output:
  - t = s >>> shift (arithmetic shift).
  - If t > 2^(OUT_W-1)-1 or t < -2^(OUT_W-1), clamp and set out_sat=1; otherwise out_sat=0.
- Reset mid-stream: in-flight pipeline samples are discarded; no out_valid until after FLUSH and WARM complete.

Decomposition:
- Package trap_filter_pkg holds:
  - ADC_W, ACC_W, OUT_W, MAX_DEPTH and derived PTR_W = $clog2(MAX_DEPTH).
  - Enum state_t {FLUSH, WARM, RUN}.
  - A typedef for the config struct (k, l, m, shift).
  - Function sat_shift(s, shift) returning {sat, value}.
- One sub-module: trap_delay_line, the circular buffer with a write port, three tap reads and a flush-clear port.

Test Plan:
1. Reset, then hold in_valid=0 -> cfg_busy=1 for exactly 64 cycles, out_valid stays 0.
2. Defaults with m=0, shift=0; 12 zero samples, then impulse 100, then zeros -> out_data after impulse, latency 2: 100,200,300,400,400,400,400,400,300,200,100,0, then stays 0.
3. Same as 2 with cfg k=4, l=8, m=2 -> 300,400,500,600,400,400,400,400,100,0,-100,-200,0.
4. k=4, l=8, m=0, shift=0, impulse 16383 -> out_data peaks at 32767 with out_sat=1 on the clamped samples, and out_sat=0 elsewhere.
5. cfg_load with k=9, l=8 -> cfg_err pulse one cycle, no flush. cfg_load with k=40, l=40 -> cfg_err. cfg_load during FLUSH -> ignored, no cfg_err.
6. Assert reset mid-pulse -> outputs 0 immediately (asynchronous), then FLUSH 64 cycles, then WARM: the first k+l accepted samples produce no out_valid.

Source files
------------

// File: rtl/trap_filter_pkg.sv
// Shared widths, FSM states, runtime config struct and output saturation for the trapezoidal shaper.
// Pure definitions: no latency, no flow control.
package trap_filter_pkg;
    localparam int ADC_W     = 14;
    localparam int ACC_W     = 32;
    localparam int M_W       = 16;
    localparam int OUT_W     = 16;
    localparam int MAX_DEPTH = 64;
    localparam int PTR_W     = $clog2(MAX_DEPTH);
    localparam int SH_W      = 5;

    typedef enum logic [1:0] {FLUSH, WARM, RUN} state_t;

    typedef struct packed {
        logic [PTR_W:0]  k;
        logic [PTR_W:0]  l;
        logic [M_W-1:0]  m;
        logic [SH_W-1:0] shift;
    } cfg_t;

    // Returns {sat, value}: arithmetic right shift of s, clamped to the signed OUT_W range.
    function automatic logic [OUT_W:0] sat_shift(input logic signed [ACC_W-1:0] s,
                                                 input logic [SH_W-1:0] shift);
        logic signed [ACC_W-1:0] t;
        logic signed [ACC_W-1:0] hi;
        logic signed [ACC_W-1:0] lo;
        hi = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
        lo = ~hi;
        t  = s >>> shift;
        if (t > hi)
            return {1'b1, hi[OUT_W-1:0]};
        else if (t < lo)
            return {1'b1, lo[OUT_W-1:0]};
        else
            return {1'b0, t[OUT_W-1:0]};
    endfunction
endpackage

// File: rtl/trap_delay_line.sv
// Circular sample buffer with one write port, a zeroing port and three combinational taps.
// Writes land on the clock edge; taps read pre-write contents; no backpressure.
module trap_delay_line
    import trap_filter_pkg::*;
(
    input  logic             clk,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_addr,
    input  logic [ADC_W-1:0] wr_data,
    input  logic             clr_en,
    input  logic [PTR_W-1:0] clr_addr,
    input  logic [PTR_W-1:0] rd_addr_a,
    input  logic [PTR_W-1:0] rd_addr_b,
    input  logic [PTR_W-1:0] rd_addr_c,
    output logic [ADC_W-1:0] rd_data_a,
    output logic [ADC_W-1:0] rd_data_b,
    output logic [ADC_W-1:0] rd_data_c
);
    logic [ADC_W-1:0] mem [MAX_DEPTH];

    // No reset here: the owner's flush sequence zeroes every entry before any tap is used.
    always_ff @(posedge clk) begin
        if (clr_en)
            mem[clr_addr] <= '0;
        else if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    assign rd_data_a = mem[rd_addr_a];
    assign rd_data_b = mem[rd_addr_b];
    assign rd_data_c = mem[rd_addr_c];
endmodule

// File: rtl/trap_filter_cfg.sv
// Runtime-configurable trapezoidal shaper for one ADC channel with flush/warm-up sequencing.
// Latency 2 cycles from accepted sample to out_valid; no backpressure, samples dropped while flushing.
module trap_filter_cfg
    import trap_filter_pkg::*;
#(
    parameter int K_DEF     = 4,
    parameter int L_DEF     = 8,
    parameter int M_DEF     = 0,
    parameter int SHIFT_DEF = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [ADC_W-1:0] in_data,
    input  logic             cfg_load,
    input  logic [PTR_W:0]   cfg_k,
    input  logic [PTR_W:0]   cfg_l,
    input  logic [M_W-1:0]   cfg_m,
    input  logic [SH_W-1:0]  cfg_shift,
    output logic             cfg_busy,
    output logic             cfg_err,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    output logic             out_sat
);
    state_t state, state_nxt;
    cfg_t cfg;
    logic [PTR_W:0]   cnt;
    logic [PTR_W-1:0] wp;
    logic accept, cfg_take, cfg_ok, warm_done;
    logic [PTR_W+1:0] kl_new, warm_len;
    logic [PTR_W-1:0] addr_k, addr_l, addr_kl;
    logic [ADC_W-1:0] tap_k, tap_l, tap_kl;

    assign accept    = in_valid && (state != FLUSH);
    assign cfg_take  = cfg_load && (state != FLUSH);
    assign kl_new    = {1'b0, cfg_k} + {1'b0, cfg_l};
    assign cfg_ok    = (cfg_k != '0) && (cfg_k <= cfg_l) && (kl_new <= (PTR_W+2)'(MAX_DEPTH));
    assign warm_len  = {1'b0, cfg.k} + {1'b0, cfg.l};
    assign warm_done = ({1'b0, cnt} + (PTR_W+2)'(1)) == warm_len;
    assign cfg_busy  = (state == FLUSH);

    // MAX_DEPTH is a power of two, so pointer arithmetic wraps for free.
    assign addr_k  = wp - cfg.k[PTR_W-1:0];
    assign addr_l  = wp - cfg.l[PTR_W-1:0];
    assign addr_kl = addr_k - cfg.l[PTR_W-1:0];

    trap_delay_line u_dl (
        .clk       (clk),
        .wr_en     (accept),
        .wr_addr   (wp),
        .wr_data   (in_data),
        .clr_en    (state == FLUSH),
        .clr_addr  (cnt[PTR_W-1:0]),
        .rd_addr_a (addr_k),
        .rd_addr_b (addr_l),
        .rd_addr_c (addr_kl),
        .rd_data_a (tap_k),
        .rd_data_b (tap_l),
        .rd_data_c (tap_kl)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            FLUSH:   if (cnt == (PTR_W+1)'(MAX_DEPTH-1)) state_nxt = WARM;
            WARM:    if (accept && warm_done) state_nxt = RUN;
            RUN:     state_nxt = RUN;
            default: state_nxt = FLUSH;
        endcase
        if (cfg_take && cfg_ok)
            state_nxt = FLUSH;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= FLUSH;
            cnt     <= '0;
            wp      <= '0;
            cfg_err <= 1'b0;
            cfg     <= '{k: (PTR_W+1)'(K_DEF), l: (PTR_W+1)'(L_DEF),
                         m: M_W'(M_DEF), shift: SH_W'(SHIFT_DEF)};
        end else begin
            state   <= state_nxt;
            cfg_err <= cfg_take && !cfg_ok;
            if (cfg_take && cfg_ok) begin
                cfg <= '{k: cfg_k, l: cfg_l, m: cfg_m, shift: cfg_shift};
                cnt <= '0;
            end else if (state == FLUSH) begin
                cnt <= (state_nxt == WARM) ? '0 : cnt + 1'b1;
                wp  <= '0;
            end else if (accept) begin
                if (state == WARM)
                    cnt <= cnt + 1'b1;
                wp <= wp + 1'b1;
            end
        end
    end

    // m and shift travel with each sample so a reconfigure never alters work already in flight.
    logic                    v0, run0, v1, run1;
    logic [ADC_W-1:0]        x0, xk0, xl0, xkl0;
    logic [M_W-1:0]          m0, m1;
    logic [SH_W-1:0]         sh0, sh1;
    logic signed [ADC_W+1:0] d_c, d1;

    assign d_c = $signed({2'b00, x0}) - $signed({2'b00, xk0})
               - $signed({2'b00, xl0}) + $signed({2'b00, xkl0});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v0 <= 1'b0; run0 <= 1'b0; v1 <= 1'b0; run1 <= 1'b0;
            x0 <= '0; xk0 <= '0; xl0 <= '0; xkl0 <= '0;
            m0 <= '0; sh0 <= '0; m1 <= '0; sh1 <= '0; d1 <= '0;
        end else begin
            v0   <= accept;
            run0 <= accept && (state == RUN);
            if (accept) begin
                x0 <= in_data; xk0 <= tap_k; xl0 <= tap_l; xkl0 <= tap_kl;
                m0 <= cfg.m;   sh0 <= cfg.shift;
            end
            v1   <= v0;
            run1 <= run0;
            if (v0) begin
                d1 <= d_c; m1 <= m0; sh1 <= sh0;
            end
        end
    end

    logic signed [ACC_W-1:0] p, s, d_ext, m_ext, mult, p_new, s_new;
    logic [OUT_W:0]          sat_res;

    // Product kept modulo 2^ACC_W, which is all the wrapping accumulators ever see.
    assign d_ext   = {{(ACC_W-ADC_W-2){d1[ADC_W+1]}}, d1};
    assign m_ext   = {{(ACC_W-M_W){1'b0}}, m1};
    assign mult    = m_ext * d_ext;
    assign p_new   = p + d_ext;
    assign s_new   = s + p_new + mult;
    assign sat_res = sat_shift(s_new, sh1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p <= '0; s <= '0;
            out_valid <= 1'b0; out_data <= '0; out_sat <= 1'b0;
        end else if (v1) begin
            p         <= p_new;
            s         <= s_new;
            out_valid <= run1;
            out_data  <= sat_res[OUT_W-1:0];
            out_sat   <= run1 && sat_res[OUT_W];
        end else begin
            out_valid <= 1'b0;
            out_sat   <= 1'b0;
            if (state == FLUSH) begin
                p <= '0; s <= '0;
            end
        end
    end
endmodule

// File: tb/tb_trap_filter_cfg.sv
// Directed bench for trap_filter_cfg: scoreboarded output stream, config handshake and flush timing.
module tb_trap_filter_cfg;
    import trap_filter_pkg::*;

    logic clk = 1'b0;
    logic reset, in_valid, cfg_load;
    logic [ADC_W-1:0] in_data;
    logic [PTR_W:0]   cfg_k, cfg_l;
    logic [M_W-1:0]   cfg_m;
    logic [SH_W-1:0]  cfg_shift;
    logic cfg_busy, cfg_err, out_valid, out_sat;
    logic [OUT_W-1:0] out_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [OUT_W-1:0] q_data[$];
    bit               q_sat[$];
    int               q_cyc[$];
    int tab_d[$];
    bit tab_s[$];
    int hist[$];
    int mk, ml, mm, msh;
    logic signed [31:0] mp, ms;
    logic [OUT_W-1:0] ed;
    bit es;
    int ec;

    trap_filter_cfg dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .cfg_load  (cfg_load),
        .cfg_k     (cfg_k),
        .cfg_l     (cfg_l),
        .cfg_m     (cfg_m),
        .cfg_shift (cfg_shift),
        .cfg_busy  (cfg_busy),
        .cfg_err   (cfg_err),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sat   (out_sat)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            checks++;
            assert (q_data.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_out_valid: got data %0d at cycle %0d, expected no output", $signed(out_data), cyc);
            end
            if (q_data.size() != 0) begin
                ed = q_data.pop_front();
                es = q_sat.pop_front();
                ec = q_cyc.pop_front();
                checks++;
                assert (out_data === ed) else begin
                    errors++;
                    $error("FAIL out_data: got %0d expected %0d", $signed(out_data), $signed(ed));
                end
                checks++;
                assert (out_sat === es) else begin
                    errors++;
                    $error("FAIL out_sat: got %0d expected %0d (data %0d)", out_sat, es, $signed(ed));
                end
                checks++;
                assert (cyc === ec) else begin
                    errors++;
                    $error("FAIL latency: output at cycle %0d expected at cycle %0d", cyc, ec);
                end
            end
        end
    end

    task automatic send(input logic [ADC_W-1:0] x, input bit exp, input logic [OUT_W-1:0] d, input bit sat);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = x;
        if (exp) begin
            q_data.push_back(d);
            q_sat.push_back(sat);
            q_cyc.push_back(cyc + 3);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic warm(input int n);
        for (int i = 0; i < n; i++) send('0, 1'b0, '0, 1'b0);
    endtask

    task automatic impulse(input int amp);
        for (int i = 0; i < tab_d.size(); i++)
            send(ADC_W'((i == 0) ? amp : 0), 1'b1, OUT_W'(tab_d[i]), tab_s[i]);
    endtask

    task automatic drain(input string tag);
        repeat (6) idle();
        chk(tag, 32'(q_data.size()), 32'd0);
    endtask

    task automatic load_cfg(input int k, input int l, input int m, input int sh, output int c0);
        @(negedge clk);
        in_valid  = 1'b0;
        cfg_load  = 1'b1;
        cfg_k     = (PTR_W+1)'(k);
        cfg_l     = (PTR_W+1)'(l);
        cfg_m     = M_W'(m);
        cfg_shift = SH_W'(sh);
        c0 = cyc;
        @(negedge clk);
        cfg_load = 1'b0;
    endtask

    task automatic wait_idle(input int c0, input int exp_len, input string tag);
        int n = 0;
        while (cfg_busy !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(cyc - c0), 32'(exp_len));
    endtask

    task automatic model_init(input int k, input int l, input int m, input int sh);
        hist.delete();
        mk = k; ml = l; mm = m; msh = sh;
        mp = '0; ms = '0;
    endtask

    task automatic model_send(input int x);
        int n, xa, xb, xc, d;
        longint md;
        logic signed [31:0] t;
        logic [OUT_W-1:0] o;
        bit sat;
        n = hist.size();
        hist.push_back(x);
        xa = (n >= mk) ? hist[n-mk] : 0;
        xb = (n >= ml) ? hist[n-ml] : 0;
        xc = (n >= mk + ml) ? hist[n-mk-ml] : 0;
        d  = x - xa - xb + xc;
        mp = mp + d;
        md = longint'(mm) * longint'(d);
        ms = ms + mp + md[31:0];
        t  = ms >>> msh;
        if (t > 32767) begin
            o = 16'h7fff; sat = 1'b1;
        end else if (t < -32768) begin
            o = 16'h8000; sat = 1'b1;
        end else begin
            o = t[15:0]; sat = 1'b0;
        end
        send(ADC_W'(x), n >= mk + ml, o, sat);
    endtask

    initial begin
        int c0, c1;
        reset = 1'b0; in_valid = 1'b0; in_data = '0; cfg_load = 1'b0;
        cfg_k = '0; cfg_l = '0; cfg_m = '0; cfg_shift = '0;
        #2 reset = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_sat", 32'(out_sat), 32'd0);
        chk("rst_cfg_err", 32'(cfg_err), 32'd0);
        chk("rst_cfg_busy", 32'(cfg_busy), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        c0 = cyc;
        wait_idle(c0, 64, "flush_len_after_reset");

        // Unit-gain trapezoid, k=4 l=8 m=0 shift=0
        load_cfg(4, 8, 0, 0, c0);
        chk("cfg_t2_err", 32'(cfg_err), 32'd0);
        chk("cfg_t2_busy", 32'(cfg_busy), 32'd1);
        wait_idle(c0, 65, "flush_len_t2");
        warm(12);
        tab_d = '{100, 200, 300, 400, 400, 400, 400, 400, 300, 200, 100, 0, 0, 0, 0};
        tab_s = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        impulse(100);
        drain("t2_drained");

        // Pole-zero term m=2
        load_cfg(4, 8, 2, 0, c0);
        wait_idle(c0, 65, "flush_len_t3");
        warm(12);
        tab_d = '{300, 400, 500, 600, 400, 400, 400, 400, 100, 0, -100, -200, 0, 0, 0};
        impulse(100);
        drain("t3_drained");

        // Full-scale impulse saturates the output
        load_cfg(4, 8, 0, 0, c0);
        wait_idle(c0, 65, "flush_len_t4");
        warm(12);
        tab_d = '{16383, 32766, 32767, 32767, 32767, 32767, 32767, 32767, 32767, 32766, 16383, 0, 0, 0};
        tab_s = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0};
        impulse(16383);
        drain("t4_drained");

        // Config rejection and acceptance boundaries
        load_cfg(9, 8, 0, 0, c0);
        chk("bad_k_gt_l_err", 32'(cfg_err), 32'd1);
        chk("bad_k_gt_l_busy", 32'(cfg_busy), 32'd0);
        @(negedge clk);
        chk("cfg_err_one_cycle", 32'(cfg_err), 32'd0);
        load_cfg(40, 40, 0, 0, c0);
        chk("bad_sum_err", 32'(cfg_err), 32'd1);
        chk("bad_sum_busy", 32'(cfg_busy), 32'd0);
        load_cfg(0, 3, 0, 0, c0);
        chk("bad_k0_err", 32'(cfg_err), 32'd1);
        load_cfg(32, 32, 0, 0, c0);
        chk("max_depth_cfg_err", 32'(cfg_err), 32'd0);
        chk("max_depth_cfg_busy", 32'(cfg_busy), 32'd1);
        wait_idle(c0, 65, "flush_len_max_depth");
        load_cfg(2, 3, 5, 1, c0);
        chk("cfg_rand_err", 32'(cfg_err), 32'd0);
        repeat (5) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 14'd5000;
        end
        load_cfg(7, 9, 3, 0, c1);
        chk("flush_ignores_valid_cfg", 32'(cfg_err), 32'd0);
        load_cfg(9, 8, 0, 0, c1);
        chk("flush_ignores_bad_cfg", 32'(cfg_err), 32'd0);
        wait_idle(c0, 65, "flush_len_with_ignored_loads");

        // Random stream with gaps against the reference model
        model_init(2, 3, 5, 1);
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) idle();
            model_send(int'($urandom_range(0, 4000)));
        end
        drain("rand_drained");

        // Reset in the middle of a pulse
        for (int i = 0; i < 6; i++) model_send(3000);
        @(negedge clk);
        #2 reset = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_data", 32'(out_data), 32'd0);
        chk("midrst_cfg_busy", 32'(cfg_busy), 32'd1);
        q_data.delete();
        q_sat.delete();
        q_cyc.delete();
        @(negedge clk);
        reset = 1'b0;
        c0 = cyc;
        wait_idle(c0, 64, "flush_len_after_midrst");
        warm(12);
        tab_d = '{100, 200, 300, 400, 400, 400, 400, 400, 300, 200, 100, 0, 0, 0, 0};
        tab_s = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        impulse(1600);
        drain("defaults_drained");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
